// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared arbiter definitions: default sizes, FSM encodings and the grant one-hot helper.
// Also provides the sync FIFO arbiter defaults that the other rtl files expand as macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ARB_NUM_REQ
`define ARB_NUM_REQ 4
`endif
`ifndef ARB_BURST_LEN
`define ARB_BURST_LEN 4
`endif
`ifndef ARB_ST_IDLE
`define ARB_ST_IDLE 1'b0
`endif
`ifndef ARB_ST_GRANT
`define ARB_ST_GRANT 1'b1
`endif

package sync_fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = `ARB_ST_IDLE,
        ST_GRANT = `ARB_ST_GRANT
    } arb_state_e;

    // Per-requester statistics counter width and its saturation value.
    localparam int              STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // NUM_REQ is capped at 16, so a 4-bit index and 16-bit one-hot cover every build.
    function automatic logic [15:0] idx_onehot(input logic [3:0] idx);
        idx_onehot = 16'(1) << idx;
    endfunction

endpackage

// File: rtl/sync_fifo_rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping modulo NUM_REQ.
// Uses a double-width request vector masked below last_idx+1, so the wrap needs no rotator.
module sync_fifo_rr_pick
    import sync_fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = `ARB_NUM_REQ,
    parameter int REQ_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [REQ_WIDTH-1:0] i_last_idx,
    output logic                 o_any_req,
    output logic [REQ_WIDTH-1:0] o_pick_idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] scan_mask;
    logic [2*NUM_REQ-1:0] req_masked;
    int                   first_idx;
    int                   wrap_idx;

    // NOTE: every always_comb output gets a default before any conditional update,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        req_dbl    = {i_req, i_req};
        scan_mask  = '0;
        first_idx  = 0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            scan_mask[k] = (k > int'(i_last_idx));
        end
        req_masked = req_dbl & scan_mask;
        // Walk downwards so the lowest qualifying bit is the one left standing.
        for (int k = 2 * NUM_REQ - 1; k >= 0; k--) begin
            if (req_masked[k]) begin
                first_idx = k;
            end
        end
        wrap_idx   = (first_idx >= NUM_REQ) ? first_idx - NUM_REQ : first_idx;
        o_pick_idx = REQ_WIDTH'(wrap_idx);
        o_any_req  = |i_req;
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one sync FIFO write port across NUM_REQ burst requesters.
// Optional per-requester beat counters on o_beat_cnt_all: define SYNC_FIFO_WR_ARB_STATS_EN.
module sync_fifo_wr_arbiter
    import sync_fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = `ARB_NUM_REQ,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int BURST_LEN  = `ARB_BURST_LEN,
    parameter int REQ_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_valid_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_req,
    output logic [NUM_REQ-1:0]            o_ready_req,
    output logic                          o_valid_s,
    output logic [DATA_WIDTH-1:0]         o_datain,
    input  logic                          i_ready_s,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     o_beat_cnt_all
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e             state_q;
    logic [REQ_WIDTH-1:0]   grant_idx_q;
    logic [REQ_WIDTH-1:0]   last_idx_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic                   busy_q;

    logic                   any_req;
    logic [REQ_WIDTH-1:0]   pick_idx;
    logic                   granted;
    logic                   grant_valid;
    logic                   beat;
    logic                   last_beat;
    logic                   release_grant;
    logic [DATA_WIDTH-1:0]  req_data [NUM_REQ];

    sync_fifo_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .REQ_WIDTH (REQ_WIDTH)
    ) u_rr_pick (
        .i_req      (i_valid_req),
        .i_last_idx (last_idx_q),
        .o_any_req  (any_req),
        .o_pick_idx (pick_idx)
    );

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data[r] = i_data_req[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Beat and release qualifiers; a dropped valid releases without a beat.
    always_comb begin
        granted       = (state_q == ST_GRANT);
        grant_valid   = i_valid_req[grant_idx_q];
        beat          = granted && grant_valid && i_ready_s;
        last_beat     = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
        release_grant = granted && (!grant_valid || (beat && last_beat));
    end

    // Data path is purely combinational: no added latency between requester and FIFO.
    always_comb begin
        o_valid_s   = 1'b0;
        o_datain    = '0;
        o_ready_req = '0;
        if (granted) begin
            o_valid_s                = grant_valid;
            o_datain                 = req_data[grant_idx_q];
            o_ready_req[grant_idx_q] = i_ready_s;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking assignments here would create order-dependent races.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= REQ_WIDTH'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q     <= ST_GRANT;
                        grant_idx_q <= pick_idx;
                        beat_cnt_q  <= '0;
                        grant_q     <= NUM_REQ'(idx_onehot(4'(pick_idx)));
                        busy_q      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                    if (release_grant) begin
                        state_q    <= ST_IDLE;
                        last_idx_q <= grant_idx_q;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = busy_q;

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];
    logic [STAT_W-1:0] stat_d [NUM_REQ];

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            stat_d[r] = stat_q[r];
            if (beat && (grant_idx_q == REQ_WIDTH'(r)) && (stat_q[r] != STAT_MAX)) begin
                stat_d[r] = stat_q[r] + STAT_W'(1);
            end
        end
    end

    // NOTE: this small counter array is cleared by reset because its contents are
    // architecturally visible; bulk data storage would normally be left unreset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                stat_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                stat_q[r] <= stat_d[r];
            end
        end
    end

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat_out
        assign o_beat_cnt_all[r*STAT_W +: STAT_W] = stat_q[r];
    end
`endif

    grant_onehot_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));

    ready_onehot_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_ready_req));

    busy_matches_grant_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_busy == (o_grant != '0));

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Self-checking bench for sync_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Table vectors, directed corner sequences and random traffic against a burst-level model.
module tb_sync_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    logic            ready;
    logic [N-1:0]    ready_req;
    logic            valid_s;
    logic [DW-1:0]   datain;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0] beat_cnt_all;
`endif

    int checks = 0;
    int errors = 0;

    // Model: owner (-1 when idle), last served requester, beats completed in this grant.
    int m_own;
    int m_last;
    int m_beats;

    always #5 clk = ~clk;

    sync_fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid_req (valid),
        .i_data_req  (data),
        .o_ready_req (ready_req),
        .o_valid_s   (valid_s),
        .o_datain    (datain),
        .i_ready_s   (ready),
        .o_grant     (grant),
        .o_busy      (busy)
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
        ,
        .o_beat_cnt_all (beat_cnt_all)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    // Compare outputs for the current cycle, then advance the model across the next edge.
    task automatic model_check();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_rdy;
        logic         e_vs;
        logic         e_busy;
        bit           found;
        if (m_own < 0) begin
            e_grant = '0;
            e_rdy   = '0;
            e_vs    = 1'b0;
            e_busy  = 1'b0;
        end else begin
            e_grant = N'(1) << m_own;
            e_rdy   = ready ? e_grant : '0;
            e_vs    = valid[m_own];
            e_busy  = 1'b1;
        end
        check("model_grant", grant, e_grant);
        check("model_ready_req", ready_req, e_rdy);
        check("model_valid_s", valid_s, e_vs);
        check("model_busy", busy, e_busy);
        if (m_own >= 0) begin
            check("model_datain", datain, data[m_own*DW +: DW]);
        end

        if (m_own < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && valid[(m_last + k) % N]) begin
                    found   = 1'b1;
                    m_own   = (m_last + k) % N;
                    m_beats = 0;
                end
            end
        end else if (!valid[m_own]) begin
            m_last = m_own;
            m_own  = -1;
        end else if (ready) begin
            m_beats++;
            if (m_beats == BL) begin
                m_last = m_own;
                m_own  = -1;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic r, input logic [N*DW-1:0] d);
        @(posedge clk);
        #1;
        valid = v;
        ready = r;
        data  = d;
        @(negedge clk);
        model_check();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid_s"}, valid_s, 0);
        check({tag, "_ready_req"}, ready_req, 0);
        check({tag, "_datain"}, datain, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid = '0;
        ready = 1'b0;
        data  = '0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         r;
        logic [N-1:0] e_grant;
        logic         e_vs;
        logic [N-1:0] e_rdy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        valid = '0;
        ready = 1'b0;
        data  = '0;
        model_reset();

        // Two requesters 0 and 2 with the FIFO always ready: alternating 4-beat bursts.
        tbl[0]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[3]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[4]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[5]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[10] = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[11] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001};

        repeat (2) @(posedge clk);
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].r, 32'h44332211);
            check($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
            check($sformatf("tbl%0d_valid_s", i), valid_s, tbl[i].e_vs);
            check($sformatf("tbl%0d_ready_req", i), ready_req, tbl[i].e_rdy);
        end

        // All four requesters continuously valid: order 0,1,2,3,0, four cycles each.
        apply_reset();
        begin
            logic [N-1:0] order [$];
            int           run_len [$];
            logic [N-1:0] prev;
            prev = '0;
            for (int c = 0; c < 25; c++) begin
                cycle(4'b1111, 1'b1, 32'hD4C3B2A1);
                check("rot_onehot0", 64'($onehot0(grant)), 1);
                if (grant != '0 && grant != prev) begin
                    order.push_back(grant);
                    run_len.push_back(1);
                end else if (grant != '0) begin
                    run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
                end
                prev = grant;
            end
            check("rot_grant_count", order.size(), 5);
            if (order.size() == 5) begin
                check("rot_order0", order[0], 4'b0001);
                check("rot_order1", order[1], 4'b0010);
                check("rot_order2", order[2], 4'b0100);
                check("rot_order3", order[3], 4'b1000);
                check("rot_order4", order[4], 4'b0001);
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("rot_len%0d", k), run_len[k], BL);
                end
            end
        end

        // Req1 alone; FIFO full for 5 cycles after beat 2; data A1..A4 must arrive in order.
        apply_reset();
        begin
            logic [7:0] d;
            logic [7:0] got [$];
            logic       rdy;
            int         beats;
            int         stall;
            d     = 8'hA1;
            beats = 0;
            stall = 0;
            for (int c = 0; c < 40 && beats < 4; c++) begin
                rdy = (stall == 0);
                cycle(4'b0010, rdy, {16'h0, d, 8'h0});
                if (!rdy) begin
                    check("stall_grant", grant, 4'b0010);
                    check("stall_valid_s", valid_s, 1);
                    check("stall_ready_req", ready_req, 0);
                    stall--;
                end else if (ready_req[1] && valid_s) begin
                    got.push_back(datain);
                    beats++;
                    d = d + 8'h1;
                    if (beats == 2) stall = 5;
                end
            end
            check("stall_beats", beats, 4);
            check("stall_words", got.size(), 4);
            for (int k = 0; k < got.size() && k < 4; k++) begin
                check($sformatf("stall_data%0d", k), got[k], 8'hA1 + 8'(k));
            end
            cycle(4'b0000, 1'b1, '0);
        end

        // Req3 drops valid after 2 beats; next pick starts at req0 with a fresh beat count.
        apply_reset();
        cycle(4'b1000, 1'b1, 32'h33221100);
        cycle(4'b1000, 1'b1, 32'h33221100);
        check("drop_grant3", grant, 4'b1000);
        cycle(4'b1000, 1'b1, 32'h33221100);
        cycle(4'b0000, 1'b1, 32'h33221100);
        check("drop_busy_release_cycle", busy, 1);
        check("drop_valid_s_release_cycle", valid_s, 0);
        cycle(4'b1001, 1'b1, 32'h33221100);
        check("drop_bubble", busy, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1001, 1'b1, 32'h33221100);
            check($sformatf("drop_next_grant%0d", k), grant, 4'b0001);
        end
        cycle(4'b1001, 1'b1, 32'h33221100);
        check("drop_full_burst_end", grant, 0);

        // Reset asserted in the middle of beat 2 of a req0 burst.
        apply_reset();
        cycle(4'b0001, 1'b1, 32'h000000E0);
        cycle(4'b0001, 1'b1, 32'h000000E0);
        cycle(4'b0001, 1'b1, 32'h000000E0);
        check("midrst_pre_valid_s", valid_s, 1);
        #1;
        rst_n = 1'b0;
        valid = '0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(4'b1111, 1'b1, 32'h44332211);
        cycle(4'b1111, 1'b1, 32'h44332211);
        check("midrst_first_priority", grant, 4'b0001);

        // Random traffic checked cycle by cycle against the model.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom);
        end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
        // Ten full bursts by req2: 40 beats on slice 2, nothing elsewhere.
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            cycle(4'b0100, 1'b1, 32'h00550000);
        end
        cycle(4'b0000, 1'b1, '0);
        cycle(4'b0000, 1'b1, '0);
        for (int r = 0; r < N; r++) begin
            check($sformatf("stats_slice%0d", r), beat_cnt_all[r*16 +: 16], (r == 2) ? 40 : 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one sync FIFO write port between NUM_REQ requesters.
- Each requester has its own valid/ready/data channel. The grant is held for a burst of up to BURST_LEN beats, then released and re-arbitrated.
- Sits directly in front of the FIFO:
  - o_valid_s/o_datain drive the FIFO write inputs.
  - i_ready_s is driven by the FIFO's o_ready_s.

Parameters:
- NUM_REQ, default 4: number of requesters, 2..16.
- DATA_WIDTH, default `DATA_WIDTH: width of each requester's data and the FIFO data.
- BURST_LEN, default 4: maximum beats per grant, at least 1.
- REQ_WIDTH, default $clog2(NUM_REQ): width of the grant index.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid_req  in  NUM_REQ  per-requester write request.
- i_data_req  in  NUM_REQ*DATA_WIDTH  requester r data at bits [r*DATA_WIDTH +: DATA_WIDTH].
- o_ready_req  out  NUM_REQ  per-requester accept, one-hot or zero.
- o_valid_s  out  1  write request to the FIFO.
- o_datain  out  DATA_WIDTH  data to the FIFO.
- i_ready_s  in  1  FIFO not full.
- o_grant  out  NUM_REQ  one-hot current grant, 0 when idle.
- o_busy  out  1  a grant is active.

Behaviour:
- Interface decision: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE; grant_idx=0; beat_cnt=0.
  - last_idx=NUM_REQ-1, so requester 0 has first priority after reset.
  - All outputs 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - o_valid_s=0, o_ready_req=0.
  - If any i_valid_req bit is set, pick the first set bit scanning last_idx+1, last_idx+2, … modulo NUM_REQ.
  - Register that index into grant_idx, clear beat_cnt, go to GRANT.
  - Arbitration latency: 1 cycle from valid to grant.
- GRANT, combinational muxing:
  - o_valid_s = i_valid_req[grant_idx].
  - o_datain = data slice of grant_idx.
  - o_ready_req[grant_idx] = i_ready_s; all other bits 0.
  - o_grant = one-hot(grant_idx); o_busy=1.
- Beat: o_valid_s & i_ready_s in GRANT. beat_cnt increments on each beat and has width $clog2(BURST_LEN+1).
- Release, i.e. go to IDLE and set last_idx=grant_idx, when either:
  - a beat occurs with beat_cnt==BURST_LEN-1; with BURST_LEN=1 this means every beat; or
  - i_valid_req[grant_idx]==0, whether the requester finished early or dropped valid. No beat occurs that cycle.
- After a release there is exactly one IDLE bubble cycle before the next grant.
- FIFO full (i_ready_s=0):
  - Grant is held and beat_cnt frozen.
  - o_valid_s stays asserted; the data must stay stable (requester obligation).
  - No timeout.
- The arbiter adds no registers on the data path: valid, data and ready are purely combinational through the mux.
- A single requester valid continuously gets back-to-back bursts of BURST_LEN beats, separated by one bubble cycle.
- Reset asserted mid-burst: immediate return to reset values. A beat in flight that cycle is lost (FIFO is reset together).

Optional Feature:
- Macro: SYNC_FIFO_WR_ARB_STATS_EN.
- Defined: adds output o_beat_cnt_all [NUM_REQ*16-1:0], holding per-requester 16-bit beat counters.
  - A requester's counter increments on each of its beats and saturates at 16'hFFFF.
  - All counters clear on reset.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to the shared sync_fifo_defines.vh:
  - `ARB_NUM_REQ (4) and `ARB_BURST_LEN (4) defaults.
  - State encodings `ARB_ST_IDLE=1'b0 and `ARB_ST_GRANT=1'b1.
- One sub-module: sync_fifo_rr_pick, a combinational round-robin picker.
  - Inputs: req[NUM_REQ] and last_idx.
  - Outputs: any_req and pick_idx[REQ_WIDTH].
  - Implementation: double-width mask scan.

Test Plan:
- Reset, then i_valid_req=4'b0101 with i_ready_s=1 held → req0 granted at cycle 2. Req0 gets 4 beats, then a 1-cycle bubble, then req2 gets 4 beats, then req0 again.
- All 4 requesters valid continuously, BURST_LEN=4 → grant order 0,1,2,3,0. Each grant lasts exactly 4 beats; o_grant is always one-hot or 0.
- Req1 alone, i_ready_s forced 0 for 5 cycles mid-burst after beat 2 → grant held, o_valid_s=1, o_ready_req=0. Beats 3-4 complete after ready returns; data 0xA3, 0xA4 reach the FIFO in order.
- Req3 deasserts valid after 2 beats → release in that cycle. Next pick starts from req0; beat_cnt is cleared on the next grant.
- i_rst_n asserted during beat 2 of a req0 burst → all outputs 0 asynchronously. After release, req0 again has first priority.
- With SYNC_FIFO_WR_ARB_STATS_EN defined, 10 bursts by req2 (40 beats) → o_beat_cnt_all slice 2 = 40 and the other slices = 0.
